// File: rtl/rng_sampler_pkg.sv
// Shared types and helpers for the bounded random sampler: FSM state encoding,
// default word width and the bound-to-mask smear used by the rejection sampler.
package rng_sampler_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Smallest all-ones mask covering bound-1; a bound of 0 selects the full range.
  function automatic logic [DEF_DATA_W-1:0] mask_from_bound(input logic [DEF_DATA_W-1:0] bound);
    logic [DEF_DATA_W-1:0] v;
    if (bound == '0) begin
      return '1;
    end
    v = bound - DEF_DATA_W'(1);
    for (int s = 1; s < DEF_DATA_W; s = s * 2) begin
      v = v | (v >> s);
    end
    return v;
  endfunction

endpackage

// File: rtl/rng_sample_fifo.sv
// First-word-fall-through circular buffer holding accepted samples.
// Flush empties the buffer; a pop in the same cycle still delivers the old head.
module rng_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !w_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by r_level and
  // an empty buffer drives zero, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/rng_range_sampler.sv
// Mask-and-reject sampler turning generator words into uniform values in [0, bound),
// prefetched into a FWFT FIFO. Define RANGE_SAMPLER_STATS_EN to build the reject counter.
module rng_range_sampler
  import rng_sampler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             rnd_i,
  input  logic                          rnd_valid_i,
  output logic                          rnd_next_o,
  input  logic [DATA_W-1:0]             bound_i,
  input  logic                          bound_we_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   reject_cnt_o
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_bound;
  logic [DATA_W-1:0] r_mask;

  logic              w_fifo_full;
  logic              w_fire;
  logic [DATA_W-1:0] w_cand;
  logic              w_accept;
  logic              w_push;

  assign w_fire   = !rst && (r_state == FILL) && rnd_valid_i && !w_fifo_full;
  assign w_cand   = rnd_i & r_mask;
  assign w_accept = (r_bound == '0) || (w_cand < r_bound);
  // A sample in flight when the bound changes is discarded with the flush.
  assign w_push   = w_fire && w_accept && !bound_we_i;

  assign rnd_next_o = w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fire) w_state_nxt = WAIT;
      WAIT:    w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
    if (bound_we_i) begin
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bound <= '0;
      r_mask  <= '1;
    end else if (bound_we_i) begin
      r_bound <= bound_i;
      r_mask  <= DATA_W'(mask_from_bound(DEF_DATA_W'(bound_i)));
    end
  end

  rng_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_cand),
    .i_pop       (out_ready_i),
    .i_flush     (bound_we_i),
    .o_data      (out_data_o),
    .o_valid     (out_valid_o),
    .o_full      (w_fifo_full),
    .o_level     (level_o)
  );

`ifdef RANGE_SAMPLER_STATS_EN
  logic        w_reject;
  logic [15:0] r_reject_cnt;

  assign w_reject = w_fire && !w_accept && !bound_we_i;

  always_ff @(posedge clk) begin
    if (rst || bound_we_i) begin
      r_reject_cnt <= '0;
    end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
      r_reject_cnt <= r_reject_cnt + 16'd1;
    end
  end

  assign reject_cnt_o = r_reject_cnt;
`else
  assign reject_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_rng_range_sampler.sv
// Self-checking bench for rng_range_sampler: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rng_range_sampler;

  localparam int DEPTH = 4;
`ifdef RANGE_SAMPLER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd_i;
  logic        rnd_valid_i;
  logic        rnd_next_o;
  logic [31:0] bound_i;
  logic        bound_we_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  level_o;
  logic [15:0] reject_cnt_o;

  rng_range_sampler #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_i        (rnd_i),
    .rnd_valid_i  (rnd_valid_i),
    .rnd_next_o   (rnd_next_o),
    .bound_i      (bound_i),
    .bound_we_i   (bound_we_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .level_o      (level_o),
    .reject_cnt_o (reject_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Generator stand-in and reference model state.
  logic [31:0] gen_q[$];
  bit          gen_en = 1'b1;
  bit          fired;
  logic [31:0] mq[$];
  logic [31:0] m_bound = 32'h0;
  bit          m_cool  = 1'b0;
  int          m_rej   = 0;

  typedef struct {
    logic [31:0] bound;
    logic [31:0] word;
    bit          acc;
    logic [31:0] value;
    int          rej;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mask as the smallest power of two minus one that covers bound-1.
  function automatic longint unsigned ref_mask(input longint unsigned b);
    longint unsigned p = 1;
    if (b == 0) return 64'hFFFF_FFFF;
    while (p < b) p = p * 2;
    return p - 1;
  endfunction

  task automatic drive_gen();
    rnd_valid_i = gen_en && (gen_q.size() != 0);
    rnd_i       = (gen_q.size() != 0) ? gen_q[0] : 32'h0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model,
  // then update the generator after the edge.
  task automatic tick();
    bit              exp_fire;
    longint unsigned mk;
    logic [31:0]     c;
    @(negedge clk);
    exp_fire = !rst && !m_cool && rnd_valid_i && (mq.size() < DEPTH);
    check("rnd_next_o", {31'h0, rnd_next_o}, {31'h0, exp_fire});
    check("out_valid_o", {31'h0, out_valid_o}, (mq.size() != 0) ? 32'h1 : 32'h0);
    check("level_o", {29'h0, level_o}, mq.size());
    if (mq.size() != 0) check("out_data_o", out_data_o, mq[0]);
    check("reject_cnt_o", {16'h0, reject_cnt_o}, STATS_ON ? m_rej : 0);
    fired = rnd_next_o;
    if (rst) begin
      mq.delete();
      m_bound = 32'h0;
      m_cool  = 1'b0;
      m_rej   = 0;
    end else begin
      if (out_ready_i && mq.size() != 0) void'(mq.pop_front());
      if (bound_we_i) begin
        mq.delete();
        m_bound = bound_i;
        m_cool  = 1'b0;
        m_rej   = 0;
      end else if (exp_fire) begin
        mk = ref_mask(longint'(m_bound));
        c  = rnd_i & mk[31:0];
        if (m_bound == 0 || c < m_bound) mq.push_back(c);
        else if (m_rej < 65535) m_rej++;
        m_cool = 1'b1;
      end else begin
        m_cool = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bound_we_i = 1'b0;
    if (fired && gen_q.size() != 0) void'(gen_q.pop_front());
    drive_gen();
  endtask

  task automatic write_bound(input logic [31:0] b);
    bound_i    = b;
    bound_we_i = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] t1_words[6];
    logic [31:0] blist[8];
    logic [31:0] w;
    int          pulses;
    int          k;

    vecs[0]  = '{32'd10,        32'h0000000C, 1'b0, 32'h0,        1};
    vecs[1]  = '{32'd10,        32'hFFFFFFF3, 1'b1, 32'h3,        1};
    vecs[2]  = '{32'd10,        32'h0000000A, 1'b0, 32'h0,        2};
    vecs[3]  = '{32'd10,        32'h00000009, 1'b1, 32'h9,        2};
    vecs[4]  = '{32'd1,         32'hFFFFFFFF, 1'b1, 32'h0,        0};
    vecs[5]  = '{32'd1,         32'h80000000, 1'b1, 32'h0,        0};
    vecs[6]  = '{32'd0,         32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0};
    vecs[7]  = '{32'h80000000,  32'hFFFFFFFF, 1'b1, 32'h7FFFFFFF, 0};
    vecs[8]  = '{32'h80000001,  32'hFFFFFFFF, 1'b0, 32'h0,        1};
    vecs[9]  = '{32'h80000001,  32'h80000000, 1'b1, 32'h80000000, 1};
    vecs[10] = '{32'd16,        32'h0000001F, 1'b1, 32'hF,        0};
    vecs[11] = '{32'd17,        32'h00000011, 1'b0, 32'h0,        1};
    vecs[12] = '{32'd17,        32'h00000030, 1'b1, 32'h10,       1};
    vecs[13] = '{32'd2,         32'h00000003, 1'b1, 32'h1,        0};

    t1_words = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D,
                 32'h0BADC0DE, 32'h13579BDF, 32'h2468ACE0};
    blist    = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd10, 32'd100,
                 32'h80000000, 32'h80000001};

    rst = 1'b1; rnd_i = 32'h0; rnd_valid_i = 1'b0;
    bound_i = 32'h0; bound_we_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_gen();
    #1;
    check("reset level", {29'h0, level_o}, 32'h0);
    check("reset valid", {31'h0, out_valid_o}, 32'h0);
    check("reset data", out_data_o, 32'h0);
    check("reset rejects", {16'h0, reject_cnt_o}, 32'h0);
    check("reset next", {31'h0, rnd_next_o}, 32'h0);

    // Fill with bound 0: words land unmasked and in order, 4 pulses then stall.
    foreach (t1_words[i]) gen_q.push_back(t1_words[i]);
    drive_gen();
    pulses = 0;
    repeat (14) begin
      tick();
      if (fired) pulses++;
    end
    check("t1 pulse count", pulses, 32'd4);
    check("t1 level full", {29'h0, level_o}, 32'd4);
    out_ready_i = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && k < 6; n++) begin
      if (out_valid_o) begin
        check("t1 order", out_data_o, t1_words[k]);
        k++;
      end
      tick();
    end
    check("t1 all words seen", k, 32'd6);
    out_ready_i = 1'b0;

    // Vector table: one word per entry, bound rewritten only when it changes.
    foreach (vecs[i]) begin
      if (i == 0 || vecs[i].bound != vecs[i-1].bound) write_bound(vecs[i].bound);
      gen_q.push_back(vecs[i].word);
      drive_gen();
      tick();
      check("vec fired", {31'h0, fired}, 32'h1);
      check("vec level", {29'h0, level_o}, vecs[i].acc ? 32'h1 : 32'h0);
      if (vecs[i].acc) check("vec value", out_data_o, vecs[i].value);
      check("vec rejects", {16'h0, reject_cnt_o}, STATS_ON ? vecs[i].rej : 0);
      tick();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
    end

    // Flush on bound write while full; refill respects the new bound.
    write_bound(32'h0);
    repeat (4) gen_q.push_back($urandom);
    drive_gen();
    repeat (10) tick();
    check("t4 level full", {29'h0, level_o}, 32'd4);
    write_bound(32'd100);
    check("t4 flushed valid", {31'h0, out_valid_o}, 32'h0);
    check("t4 flushed level", {29'h0, level_o}, 32'h0);
    repeat (12) gen_q.push_back($urandom);
    drive_gen();
    repeat (30) tick();
    out_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (out_valid_o) check("t4 below bound", (out_data_o < 32'd100) ? 32'h1 : 32'h0, 32'h1);
      tick();
    end
    out_ready_i = 1'b0;
    gen_q.delete();
    drive_gen();

    // Simultaneous push and pop at level 3.
    write_bound(32'h0);
    gen_q.push_back(32'h11111111);
    gen_q.push_back(32'h22222222);
    gen_q.push_back(32'h33333333);
    drive_gen();
    repeat (8) tick();
    check("t5 level 3", {29'h0, level_o}, 32'd3);
    gen_q.push_back(32'h44444444);
    drive_gen();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("t5 push pop fired", {31'h0, fired}, 32'h1);
    check("t5 level kept", {29'h0, level_o}, 32'd3);
    check("t5 head advanced", out_data_o, 32'h22222222);

    // Reset during the wait cycle after a pulse.
    write_bound(32'd10);
    gen_q.push_back(32'h00000003);
    gen_q.push_back(32'hFFFFFFF5);
    drive_gen();
    tick();
    check("t6 pulse", {31'h0, fired}, 32'h1);
    rst    = 1'b1;
    gen_en = 1'b0;
    drive_gen();
    tick();
    rst = 1'b0;
    #1;
    check("t6 level", {29'h0, level_o}, 32'h0);
    check("t6 valid", {31'h0, out_valid_o}, 32'h0);
    check("t6 data", out_data_o, 32'h0);
    check("t6 rejects", {16'h0, reject_cnt_o}, 32'h0);
    check("t6 next", {31'h0, rnd_next_o}, 32'h0);
    gen_en = 1'b1;
    drive_gen();
    tick();
    check("t6 unmasked", out_data_o, 32'hFFFFFFF5);
    tick();
    out_ready_i = 1'b1;
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      gen_en      = ($urandom_range(0, 7) != 0);
      while (gen_q.size() < 3) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w = w & 32'h000000FF;
        gen_q.push_back(w);
      end
      if ($urandom_range(0, 49) == 0) begin
        bound_i    = ($urandom_range(0, 4) == 0) ? $urandom : blist[$urandom_range(0, 7)];
        bound_we_i = 1'b1;
      end
      rst = ($urandom_range(0, 499) == 0);
      drive_gen();
      tick();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
